serial_sub: RTL and testbench

- Bit-serial unsigned subtractor. Computes diff = a - b (mod 2^WIDTH) and a final borrow, LSB first, one bit per clock.
- Built from two half-subtractor cells chained as a full subtractor, with a borrow flip-flop between bit steps.
- It is the subtract-direction counterpart to the team's adder cells.
- Used where area matters more than latency. Sits between a valid/ready producer and a valid/ready consumer.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/half_sub.sv | 12 +
 rtl/serial_sub.sv | 109 ++++++++++
 tb/tb_serial_sub.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic cells.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned SERIAL_WIDTH = 8;

endpackage

// File: rtl/half_sub.sv
// Half subtractor: d = x - y, bo = borrow out. Purely combinational.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Two chained half subtractors form the full subtractor; the borrow
// is carried between bit steps in borrow_ff.
module serial_sub
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             borrow_ff;

  logic             d1;
  logic             b1;
  logic             d;
  logic             b2;
  logic             bout;
  logic [WIDTH-1:0] res_next;

  half_sub u_hs1 (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .d  (d1),
    .bo (b1)
  );

  half_sub u_hs2 (
    .x  (d1),
    .y  (borrow_ff),
    .d  (d),
    .bo (b2)
  );

  // Full-subtractor borrow and the result register after this bit step.
  always_comb begin
    bout     = b1 | b2;
    res_next = {d, res_sr[WIDTH-1:1]};
  end

  // Control FSM with datapath shifting and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      cnt       <= '0;
      borrow_ff <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr      <= a;
            b_sr      <= b;
            cnt       <= '0;
            borrow_ff <= 1'b0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          res_sr    <= res_next;
          borrow_ff <= bout;
          cnt       <= cnt + 1'b1;
          if (cnt == LastBit) begin
            // Latch the outputs so they stay put under backpressure.
            diff      <= res_next;
            borrow    <= bout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed cases on an 8-bit instance,
// randomized back-to-back traffic on a 16-bit instance, scoreboard checking.
module tb_serial_sub;

  typedef struct {
    logic [63:0] d;
    logic        b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit instance signals
  logic       rst_n8 = 1'b0;
  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       out_valid8;
  logic       out_ready8 = 1'b1;
  logic [7:0] diff8;
  logic       borrow8;

  // 16-bit instance signals
  logic        rst_n16 = 1'b0;
  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        out_valid16;
  logic        out_ready16 = 1'b1;
  logic [15:0] diff16;
  logic        borrow16;

  exp_t q8[$];
  exp_t q16[$];
  bit   rand_done = 1'b0;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .diff      (diff8),
    .borrow    (borrow8)
  );

  serial_sub #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n16),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .diff      (diff16),
    .borrow    (borrow16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain modular arithmetic and unsigned compare.
  function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                 input int unsigned w);
    exp_t e;
    longint unsigned mask;
    mask = (64'd1 << w) - 64'd1;
    e.d  = (a - b) & mask;
    e.b  = (a < b);
    return e;
  endfunction

  // Presents one operand pair; returns at the falling edge after the accept edge.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b);
    int n;
    for (n = 0; n < 40 && !in_ready8; n++) @(negedge clk);
    if (!in_ready8) chk("in_ready8_timeout", 64'(in_ready8), 64'd1);
    a8        = a;
    b8        = b;
    in_valid8 = 1'b1;
    q8.push_back(model(64'(a), 64'(b), 8));
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  // Counts falling edges until out_valid8 is seen; n is the edge index.
  task automatic wait_out8(output int n);
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (out_valid8) return;
    end
    chk("out_valid8_timeout", 64'(out_valid8), 64'd1);
  endtask

  // Monitor for the 8-bit instance: scoreboard pop on transfer, hold check under backpressure.
  initial begin
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    logic       pb;
    exp_t       e;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n8 && pv && !pr) begin
        chk("hold8_valid", 64'(out_valid8), 64'd1);
        chk("hold8_data", {55'd0, diff8, borrow8}, {55'd0, pd, pb});
      end
      if (rst_n8 && out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          chk("unexpected8", 64'(out_valid8), 64'd0);
        end else begin
          e = q8.pop_front();
          chk("diff8", 64'(diff8), e.d);
          chk("borrow8", 64'(borrow8), 64'(e.b));
        end
      end
      pv = rst_n8 && out_valid8;
      pr = out_ready8;
      pd = diff8;
      pb = borrow8;
    end
  end

  // Monitor for the 16-bit instance.
  initial begin
    logic        pv;
    logic        pr;
    logic [15:0] pd;
    logic        pb;
    exp_t        e;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n16 && pv && !pr) begin
        chk("hold16_valid", 64'(out_valid16), 64'd1);
        chk("hold16_data", {47'd0, diff16, borrow16}, {47'd0, pd, pb});
      end
      if (rst_n16 && out_valid16 && out_ready16) begin
        if (q16.size() == 0) begin
          chk("unexpected16", 64'(out_valid16), 64'd0);
        end else begin
          e = q16.pop_front();
          chk("diff16", 64'(diff16), e.d);
          chk("borrow16", 64'(borrow16), 64'(e.b));
        end
      end
      pv = rst_n16 && out_valid16;
      pr = out_ready16;
      pd = diff16;
      pb = borrow16;
    end
  end

  // Random backpressure on the 16-bit consumer.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_done) out_ready16 = 1'b1;
      else out_ready16 = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    bit   seen;
    exp_t e;

    repeat (3) @(negedge clk);
    rst_n8  = 1'b1;
    rst_n16 = 1'b1;
    #1;
    chk("rst_in_ready8", 64'(in_ready8), 64'd1);
    chk("rst_out_valid8", 64'(out_valid8), 64'd0);
    chk("rst_diff8", 64'(diff8), 64'd0);
    chk("rst_borrow8", 64'(borrow8), 64'd0);
    chk("rst_in_ready16", 64'(in_ready16), 64'd1);
    chk("rst_out_valid16", 64'(out_valid16), 64'd0);

    fork
      begin : directed
        // Latency and return to idle
        drive8(8'd100, 8'd37);
        wait_out8(n);
        chk("latency8", 64'(n), 64'd8);
        chk("busy_in_ready8", 64'(in_ready8), 64'd0);
        @(negedge clk);
        chk("drop_out_valid8", 64'(out_valid8), 64'd0);
        chk("idle_in_ready8", 64'(in_ready8), 64'd1);

        // Borrow and equality boundaries
        drive8(8'd5, 8'd9);
        wait_out8(n);
        @(negedge clk);
        drive8(8'h00, 8'h01);
        wait_out8(n);
        @(negedge clk);
        drive8(8'h00, 8'hFF);
        wait_out8(n);
        @(negedge clk);
        drive8(8'hA5, 8'hA5);
        wait_out8(n);
        @(negedge clk);

        // Backpressure: five stalled cycles, then a single transfer
        out_ready8 = 1'b0;
        drive8(8'd200, 8'd55);
        wait_out8(n);
        repeat (5) @(negedge clk);
        out_ready8 = 1'b1;
        @(negedge clk);
        chk("bp_drop8", 64'(out_valid8), 64'd0);

        // Operands offered while busy must be ignored
        drive8(8'd10, 8'd3);
        @(negedge clk);
        a8        = 8'd99;
        b8        = 8'd1;
        in_valid8 = 1'b1;
        repeat (2) @(negedge clk);
        in_valid8 = 1'b0;
        wait_out8(n);
        repeat (4) @(negedge clk);
        chk("busy_ignored8", 64'(q8.size()), 64'd0);

        // Reset in the middle of an operation aborts it
        drive8(8'd50, 8'd20);
        repeat (4) @(negedge clk);
        rst_n8 = 1'b0;
        @(negedge clk);
        chk("abort_in_ready8", 64'(in_ready8), 64'd1);
        chk("abort_out_valid8", 64'(out_valid8), 64'd0);
        rst_n8 = 1'b1;
        e = q8.pop_back();
        seen = 1'b0;
        repeat (14) begin
          @(negedge clk);
          if (out_valid8) seen = 1'b1;
        end
        chk("abort_no_result8", 64'(seen), 64'd0);
        drive8(8'd50, 8'd20);
        wait_out8(n);
        @(negedge clk);
      end
      begin : random16
        int sent;
        sent = 0;
        while (sent < 200) begin
          @(negedge clk);
          if (in_ready16) begin
            a16        = 16'($urandom);
            b16        = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b16 = a16;
            in_valid16 = 1'b1;
            q16.push_back(model(64'(a16), 64'(b16), 16));
            sent++;
          end else begin
            in_valid16 = 1'b0;
            a16        = 16'($urandom);
            b16        = 16'($urandom);
          end
        end
        @(negedge clk);
        in_valid16 = 1'b0;
        rand_done  = 1'b1;
      end
    join

    for (int i = 0; i < 100 && (q8.size() != 0 || q16.size() != 0); i++) @(negedge clk);
    chk("drain8", 64'(q8.size()), 64'd0);
    chk("drain16", 64'(q16.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
